// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration bitstream loader and the
// fabric chain logic.
//   - chain id constants carried in bits [3:0] of a frame header
//   - loader FSM state enumeration
//   - default width of the per-frame bit count
//   - helper that classifies a header id as a real chain
package cfg_pkg;

   localparam int unsigned LEN_W_DEF = 16;

   localparam logic [3:0] CHAIN_CLB  = 4'd0;
   localparam logic [3:0] CHAIN_CB   = 4'd1;
   localparam logic [3:0] CHAIN_SB   = 4'd2;
   localparam logic [3:0] CHAIN_IO   = 4'd3;
   localparam logic [3:0] END_ID_DEF = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_LOAD,
      ST_SHIFT,
      ST_ERR
   } state_t;

   function automatic logic is_chain_id(input logic [3:0] id);
      return (id <= CHAIN_IO);
   endfunction

endpackage

// File: rtl/cfg_bitstream_loader_if.sv
// cfg_bitstream_loader_if: byte-wide valid/ready stream from the host.
//   in_data  : stream byte (master -> slave)
//   in_valid : in_data valid (master -> slave)
//   in_ready : slave accepts in_data this cycle (slave -> master)
// A byte transfers on a clock edge where in_valid && in_ready.
interface cfg_bitstream_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/cfg_byte_serializer.sv
// cfg_byte_serializer: holds one configuration byte and emits it LSB first.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : capture i_data and the number of valid bits i_nbits (1..8)
//   i_data     : byte to serialise
//   i_nbits    : bits of i_data still belonging to the frame
//   i_shift    : advance to the next bit
//   o_bit      : current bit
//   o_last     : current bit is the last valid bit of the loaded byte
module cfg_byte_serializer (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [7:0] i_data,
   input  logic [3:0] i_nbits,
   input  logic       i_shift,
   output logic       o_bit,
   output logic       o_last
);

   logic [7:0] r_sreg;
   logic [3:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
         r_cnt  <= i_nbits;
      end else if (i_shift) begin
         r_sreg <= {1'b0, r_sreg[7:1]};
         if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign o_bit  = r_sreg[0];
   assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader: parses framed configuration bytes from the host and
// shifts them, one bit per clock, into the CLB/CB/SB/IO configuration chains.
//   clk, reset          : clock, asynchronous active-high reset
//   i_start             : one-cycle pulse, opens a configuration session
//   s_in                : host byte stream (slave side)
//   o_prgm_b            : active-low global program, low while a session is open
//   o_<chain>_prgm_b    : active-high shift enable of that chain
//   o_bit_in_<chain>    : serial configuration bit of that chain
//   o_busy              : session in progress
//   o_done              : one-cycle pulse when the end header is accepted
//   o_err               : illegal chain id seen; cleared by the next i_start
// Frame: HDR (id in [3:0]), LEN_LO, LEN_HI, then ceil(N/8) data bytes.
module cfg_bitstream_loader
   import cfg_pkg::*;
#(
   parameter int unsigned LEN_W  = LEN_W_DEF,
   parameter logic [3:0]  END_ID = END_ID_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_start,
   cfg_bitstream_loader_if.slave    s_in,
   output logic                     o_prgm_b,
   output logic                     o_clb_prgm_b,
   output logic                     o_cb_prgm_b,
   output logic                     o_sb_prgm_b,
   output logic                     o_io_prgm_b,
   output logic                     o_bit_in_clb,
   output logic                     o_bit_in_cb,
   output logic                     o_bit_in_sb,
   output logic                     o_bit_in_io,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic             r_done;
   logic             r_err;
   logic [1:0]       r_chain;
   logic [7:0]       r_len_lo;
   logic [LEN_W-1:0] r_remaining;
   logic [3:0]       r_bit_hold;

   logic             w_xfer;
   logic [3:0]       w_hdr_id;
   logic [LEN_W-1:0] w_len;
   logic [3:0]       w_ser_nbits;
   logic             w_ser_load;
   logic             w_ser_shift;
   logic             w_ser_bit;
   logic             w_ser_last;
   logic [3:0]       w_en;

   assign w_xfer   = s_in.in_valid && r_in_ready;
   assign w_hdr_id = s_in.in_data[3:0];
   // Count bits above LEN_W in the high byte are dropped.
   assign w_len    = {s_in.in_data[LEN_W-9:0], r_len_lo};
   assign w_ser_nbits = (r_remaining >= LEN_W'(8)) ? 4'd8 : r_remaining[3:0];

   cfg_byte_serializer u_ser (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_ser_load),
      .i_data  (s_in.in_data),
      .i_nbits (w_ser_nbits),
      .i_shift (w_ser_shift),
      .o_bit   (w_ser_bit),
      .o_last  (w_ser_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ser_load  = 1'b0;
      w_ser_shift = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (w_xfer) begin
               if (is_chain_id(w_hdr_id)) begin
                  w_state_nxt = ST_LEN_LO;
               end else if (w_hdr_id == END_ID) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_ERR;
               end
            end
         end
         ST_LEN_LO: begin
            if (w_xfer) begin
               w_state_nxt = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (w_xfer) begin
               w_state_nxt = (w_len == '0) ? ST_HDR : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_xfer) begin
               w_ser_load  = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_ser_shift = 1'b1;
            // Remaining still counts the bit going out this cycle.
            if (w_ser_last) begin
               w_state_nxt = (r_remaining == LEN_W'(1)) ? ST_HDR : ST_LOAD;
            end
         end
         ST_ERR: begin
            if (i_start) begin
               w_state_nxt = ST_HDR;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_ready  <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_chain     <= '0;
         r_len_lo    <= '0;
         r_remaining <= '0;
         r_bit_hold  <= '0;
      end else begin
         r_in_ready <= (w_state_nxt == ST_HDR)    || (w_state_nxt == ST_LEN_LO) ||
                       (w_state_nxt == ST_LEN_HI) || (w_state_nxt == ST_LOAD);
         r_done     <= (r_state == ST_HDR) && w_xfer &&
                       !is_chain_id(w_hdr_id) && (w_hdr_id == END_ID);
         // ERR is left only through start or reset, so err tracks entry to it.
         r_err      <= (w_state_nxt == ST_ERR);
         if ((r_state == ST_HDR) && w_xfer && is_chain_id(w_hdr_id)) begin
            r_chain <= w_hdr_id[1:0];
         end
         if ((r_state == ST_LEN_LO) && w_xfer) begin
            r_len_lo <= s_in.in_data;
         end
         if ((r_state == ST_LEN_HI) && w_xfer) begin
            r_remaining <= w_len;
         end else if ((r_state == ST_SHIFT) && (r_remaining != '0)) begin
            r_remaining <= r_remaining - LEN_W'(1);
         end
         if (r_state == ST_SHIFT) begin
            r_bit_hold[r_chain] <= w_ser_bit;
         end
      end
   end

   assign w_en = (r_state == ST_SHIFT) ? (4'b0001 << r_chain) : '0;

   assign s_in.in_ready = r_in_ready;
   assign o_prgm_b      = (r_state == ST_IDLE);
   assign o_busy        = (r_state != ST_IDLE);
   assign o_done        = r_done;
   assign o_err         = r_err;

   assign o_clb_prgm_b  = w_en[CHAIN_CLB[1:0]];
   assign o_cb_prgm_b   = w_en[CHAIN_CB[1:0]];
   assign o_sb_prgm_b   = w_en[CHAIN_SB[1:0]];
   assign o_io_prgm_b   = w_en[CHAIN_IO[1:0]];

   // Idle chains keep presenting the last bit they were given.
   assign o_bit_in_clb  = w_en[CHAIN_CLB[1:0]] ? w_ser_bit : r_bit_hold[CHAIN_CLB[1:0]];
   assign o_bit_in_cb   = w_en[CHAIN_CB[1:0]]  ? w_ser_bit : r_bit_hold[CHAIN_CB[1:0]];
   assign o_bit_in_sb   = w_en[CHAIN_SB[1:0]]  ? w_ser_bit : r_bit_hold[CHAIN_SB[1:0]];
   assign o_bit_in_io   = w_en[CHAIN_IO[1:0]]  ? w_ser_bit : r_bit_hold[CHAIN_IO[1:0]];

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// tb_cfg_bitstream_loader: directed bench for cfg_bitstream_loader.
// A negedge monitor records every enabled chain bit; the stimulus sends
// frames from dbuf and compares the recorded bits with dbuf LSB first.
module tb_cfg_bitstream_loader;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic prgm_b, clb_en, cb_en, sb_en, io_en;
   logic clb_bit, cb_bit, sb_bit, io_bit;
   logic busy, done, err;

   cfg_bitstream_loader_if u_if ();

   cfg_bitstream_loader #(
      .LEN_W  (16),
      .END_ID (4'hF)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start),
      .s_in         (u_if),
      .o_prgm_b     (prgm_b),
      .o_clb_prgm_b (clb_en),
      .o_cb_prgm_b  (cb_en),
      .o_sb_prgm_b  (sb_en),
      .o_io_prgm_b  (io_en),
      .o_bit_in_clb (clb_bit),
      .o_bit_in_cb  (cb_bit),
      .o_bit_in_sb  (sb_bit),
      .o_bit_in_io  (io_bit),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [7:0]  dbuf [0:127];
   bit          got_q   [4][$];
   int unsigned got_cyc [4][$];
   int unsigned cyc     = 0;
   int unsigned n_done  = 0;
   int unsigned n_multi = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if ($countones({io_en, sb_en, cb_en, clb_en}) > 1) n_multi <= n_multi + 1;
      if (done) n_done <= n_done + 1;
      if (clb_en) begin got_q[0].push_back(clb_bit); got_cyc[0].push_back(cyc); end
      if (cb_en)  begin got_q[1].push_back(cb_bit);  got_cyc[1].push_back(cyc); end
      if (sb_en)  begin got_q[2].push_back(sb_bit);  got_cyc[2].push_back(cyc); end
      if (io_en)  begin got_q[3].push_back(io_bit);  got_cyc[3].push_back(cyc); end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned n;
      for (int unsigned g = 0; g < gap; g++) begin
         u_if.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      u_if.in_data  = b;
      u_if.in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (u_if.in_ready) break;
         n++;
         if (n > 5000) begin
            check("byte_accept_timeout", n, 0);
            u_if.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      u_if.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [15:0] n,
                             input int unsigned nbytes, input int unsigned max_gap);
      send_byte(hdr, 0);
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
      for (int unsigned i = 0; i < nbytes; i++) begin
         send_byte(dbuf[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   function automatic int unsigned en_total();
      return got_q[0].size() + got_q[1].size() + got_q[2].size() + got_q[3].size();
   endfunction

   task automatic check_frame(input string tag, input int unsigned ch,
                              input int unsigned base, input int unsigned n);
      int unsigned mis = 0;
      check({tag, "_count"}, got_q[ch].size() - base, n);
      if (got_q[ch].size() - base == n) begin
         for (int unsigned k = 0; k < n; k++) begin
            if (got_q[ch][base + k] !== dbuf[k / 8][k % 8]) mis++;
         end
      end
      check({tag, "_bit_mismatches"}, mis, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned b0, b1, b2, b3, tot, cnt, rdy_seen, n;
      logic [11:0] v12;
      logic [7:0]  v8;

      reset = 1'b1; start = 1'b0;
      u_if.in_valid = 1'b0; u_if.in_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_prgm_b", prgm_b, 1);
      check("rst_enables", {io_en, sb_en, cb_en, clb_en}, 0);
      check("rst_bits", {io_bit, sb_bit, cb_bit, clb_bit}, 0);
      check("rst_in_ready", u_if.in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1 reset = 1'b0;

      pulse_start();
      @(negedge clk);
      check("start_prgm_b", prgm_b, 0);
      check("start_busy", busy, 1);
      check("start_in_ready", u_if.in_ready, 1);
      @(posedge clk); #1;

      // CLB frame, 296 bits, header upper nibble non-zero
      for (int unsigned i = 0; i < 37; i++) dbuf[i] = 8'((i * 29 + 7) & 255);
      dbuf[36] = 8'hC3;
      b0 = got_q[0].size();
      tot = en_total();
      send_frame(8'h50, 16'd296, 37, 0);
      check_frame("clb296", 0, b0, 296);
      if (got_q[0].size() >= b0 + 296)
         check("clb296_span_cycles", got_cyc[0][b0 + 295] - got_cyc[0][b0], 331);
      check("clb296_other_enables", en_total() - tot - (got_q[0].size() - b0), 0);
      check("clb_bit_hold", clb_bit, 1);

      // CB frame, 12 bits from A5, 03
      dbuf[0] = 8'hA5; dbuf[1] = 8'h03;
      b1 = got_q[1].size();
      send_frame(8'h01, 16'd12, 2, 0);
      check("cb12_count", got_q[1].size() - b1, 12);
      v12 = '0;
      if (got_q[1].size() >= b1 + 12)
         for (int unsigned k = 0; k < 12; k++) v12[k] = got_q[1][b1 + k];
      check("cb12_bits", v12, 12'h3A5);
      check("clb_bit_still_held", clb_bit, 1);

      // SB N=0 then IO N=8 of 0xFF
      b2 = got_q[2].size(); b3 = got_q[3].size();
      send_frame(8'h02, 16'd0, 0, 0);
      dbuf[0] = 8'hFF;
      send_frame(8'h03, 16'd8, 1, 0);
      check("sb0_no_enables", got_q[2].size() - b2, 0);
      check("io8_count", got_q[3].size() - b3, 8);
      v8 = '0;
      if (got_q[3].size() >= b3 + 8)
         for (int unsigned k = 0; k < 8; k++) v8[k] = got_q[3][b3 + k];
      check("io8_bits", v8, 8'hFF);
      check("io_bit_hold", io_bit, 1);
      check("no_multi_enable", n_multi, 0);

      // End of session
      cnt = n_done;
      send_byte(8'h0F, 0);
      @(negedge clk);
      check("end_done_high", done, 1);
      check("end_prgm_b", prgm_b, 1);
      check("end_busy", busy, 0);
      check("end_in_ready", u_if.in_ready, 0);
      @(negedge clk);
      check("end_done_low", done, 0);
      repeat (3) @(negedge clk);
      check("end_done_pulses", n_done - cnt, 1);

      // Illegal header
      pulse_start();
      #1;
      tot = en_total();
      send_byte(8'h07, 0);
      @(negedge clk);
      check("bad_hdr_err", err, 1);
      check("bad_hdr_in_ready", u_if.in_ready, 0);
      check("bad_hdr_prgm_b", prgm_b, 0);
      @(posedge clk); #1;
      u_if.in_data = 8'h00; u_if.in_valid = 1'b1;
      rdy_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (u_if.in_ready) rdy_seen++;
      end
      @(posedge clk); #1 u_if.in_valid = 1'b0;
      check("err_in_ready_stays_low", rdy_seen, 0);
      check("err_no_enables", en_total() - tot, 0);
      check("err_sticky", err, 1);
      pulse_start();
      @(negedge clk);
      check("restart_err_cleared", err, 0);
      check("restart_in_ready", u_if.in_ready, 1);
      @(posedge clk); #1;
      dbuf[0] = 8'h01;
      b1 = got_q[1].size();
      send_frame(8'h01, 16'd1, 1, 0);
      check("restart_cb1_count", got_q[1].size() - b1, 1);
      if (got_q[1].size() > b1) check("restart_cb1_bit", got_q[1][b1], 1);
      send_byte(8'h0F, 0);

      // SB 768 bits with irregular in_valid
      pulse_start();
      #1;
      for (int unsigned i = 0; i < 96; i++) dbuf[i] = 8'($urandom);
      b2 = got_q[2].size();
      send_frame(8'h02, 16'd768, 96, 3);
      check_frame("sb768_gaps", 2, b2, 768);

      // Reset in the middle of a second 768-bit SB frame
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      for (int unsigned i = 0; i < 3; i++) send_byte(dbuf[i], 0);
      n = 0;
      forever begin
         @(negedge clk);
         if (sb_en) break;
         n++;
         if (n > 100) begin
            check("sb_shift_timeout", n, 0);
            break;
         end
      end
      #2 reset = 1'b1;
      #1;
      check("midrst_enables", {io_en, sb_en, cb_en, clb_en}, 0);
      check("midrst_prgm_b", prgm_b, 1);
      check("midrst_in_ready", u_if.in_ready, 0);
      check("midrst_busy", busy, 0);
      cnt = got_q[2].size();
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("midrst_no_more_shift", got_q[2].size() - cnt, 0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
